// File: rtl/seq_pkg.sv
// Shared definitions for the score sequencer and the note player:
// opcodes, FSM states, repeat-stack entry layout and agreed constants.
package seq_pkg;

  localparam logic [3:0] OP_END  = 4'h0;
  localparam logic [3:0] OP_BPM  = 4'h1;
  localparam logic [3:0] OP_REP1 = 4'h2;
  localparam logic [3:0] OP_REP2 = 4'h3;

  localparam logic [11:0] DEFAULT_BPM = 12'd96;
  localparam logic [15:0] REST_WORD   = 16'h8000;

  typedef enum logic [2:0] {
    S_FETCH,
    S_WAIT,
    S_DECODE,
    S_OFFER,
    S_HALT,
    S_FAULT
  } seq_state_t;

  typedef struct packed {
    logic [17:0] addr;
    logic [5:0]  cnt;
  } rep_entry_t;

endpackage

// File: rtl/rep_stack.sv
// LIFO of active repeat loops. Each entry holds the REP2 address that owns
// the loop and the number of extra passes still to play.
module rep_stack
  import seq_pkg::*;
#(
  parameter int DEPTH = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic        dec,
  input  rep_entry_t  push_entry,
  output logic [17:0] top_addr,
  output logic [5:0]  top_cnt,
  output logic        empty,
  output logic        full
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  rep_entry_t    mem [DEPTH];
  logic [PW-1:0] sp;
  logic [IW-1:0] top_idx;
  logic [IW-1:0] wr_idx;

  assign top_idx  = IW'(sp - PW'(1));
  assign wr_idx   = IW'(sp);
  assign empty    = (sp == '0);
  assign full     = (sp == DEPTH_P);
  assign top_addr = mem[top_idx].addr;
  assign top_cnt  = mem[top_idx].cnt;

  // Stack pointer and entry storage; push, pop and decrement are exclusive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_idx] <= push_entry;
      sp          <= sp + PW'(1);
    end else if (pop) begin
      sp <= sp - PW'(1);
    end else if (dec) begin
      mem[top_idx].cnt <= top_cnt - 6'd1;
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Score sequencer: fetches words from asynchronous SRAM, runs BPM, repeat
// and end words internally and offers note words to the player.
module note_sequencer #(
  parameter int          READ_WAIT   = 2,
  parameter int          DEPTH       = 7,
  parameter logic [11:0] DEFAULT_BPM = seq_pkg::DEFAULT_BPM
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic [17:0] SRAM_A,
  input  logic [15:0] SRAM_D,
  output logic        NOTE_VALID,
  input  logic        NOTE_READY,
  output logic [15:0] NOTE_INS,
  output logic [11:0] NOTE_BPM,
  output logic        DONE,
  output logic        ERR
);
  import seq_pkg::*;

  localparam logic [7:0] WAIT_LAST = 8'(READ_WAIT - 1);

  seq_state_t  state, state_next;
  logic [17:0] pc, pc_next, pc_inc, target;
  logic [15:0] ir;
  logic [11:0] bpm, hi;
  logic        rep1_pending;
  logic [7:0]  wait_cnt;
  logic        is_note, is_end, is_bpm, is_rep1, is_rep2;
  logic        push, pop, dec, fault, accept, wait_done;
  logic [17:0] top_addr;
  logic [5:0]  top_cnt;
  logic        empty, full;
  rep_entry_t  push_entry;

  assign is_note    = ir[15];
  assign is_end     = (ir[15:12] == OP_END);
  assign is_bpm     = (ir[15:12] == OP_BPM);
  assign is_rep1    = (ir[15:12] == OP_REP1);
  assign is_rep2    = (ir[15:12] == OP_REP2);
  assign pc_inc     = pc + 18'd1;
  assign target     = {hi, ir[11:6]};
  assign wait_done  = (wait_cnt == WAIT_LAST);
  assign accept     = (state == S_OFFER) && NOTE_READY;
  assign push_entry = '{addr: pc, cnt: ir[5:0] - 6'd1};

  rep_stack #(.DEPTH(DEPTH)) u_stack (
    .clk       (CLK),
    .rst       (RESET),
    .push      (push),
    .pop       (pop),
    .dec       (dec),
    .push_entry(push_entry),
    .top_addr  (top_addr),
    .top_cnt   (top_cnt),
    .empty     (empty),
    .full      (full)
  );

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= S_FETCH;
    else       state <= state_next;
  end

  // Next-state decision; HALT and FAULT only leave through reset.
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:  state_next = S_WAIT;
      S_WAIT:   if (wait_done) state_next = S_DECODE;
      S_DECODE: begin
        if (fault)        state_next = S_FAULT;
        else if (is_note) state_next = S_OFFER;
        else if (is_end)  state_next = S_HALT;
        else              state_next = S_FETCH;
      end
      S_OFFER:  if (accept) state_next = S_FETCH;
      default:  state_next = state;
    endcase
  end

  // Control strobes: next pc, stack operations and protocol faults.
  always_comb begin
    push    = 1'b0;
    pop     = 1'b0;
    dec     = 1'b0;
    fault   = 1'b0;
    pc_next = pc;
    if (state == S_DECODE) begin
      if (is_note || is_end) begin
        pc_next = pc;
      end else if (is_bpm || is_rep1) begin
        pc_next = pc_inc;
      end else if (is_rep2) begin
        if (!rep1_pending) begin
          fault = 1'b1;
        end else if (!empty && (top_addr == pc)) begin
          if (top_cnt == 6'd0) begin
            pop     = 1'b1;
            pc_next = pc_inc;
          end else begin
            dec     = 1'b1;
            pc_next = target;
          end
        end else if (ir[5:0] == 6'd0) begin
          pc_next = pc_inc;
        end else if (full) begin
          fault = 1'b1;
        end else begin
          push    = 1'b1;
          pc_next = target;
        end
      end else begin
        fault = 1'b1;
      end
    end else if (accept) begin
      pc_next = pc_inc;
    end
  end

  // Datapath registers: address, instruction latch, BPM, repeat prefix, outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pc           <= '0;
      SRAM_A       <= '0;
      wait_cnt     <= '0;
      ir           <= '0;
      bpm          <= DEFAULT_BPM;
      hi           <= '0;
      rep1_pending <= 1'b0;
      NOTE_VALID   <= 1'b0;
      NOTE_INS     <= '0;
      NOTE_BPM     <= DEFAULT_BPM;
      DONE         <= 1'b0;
      ERR          <= 1'b0;
    end else begin
      pc <= pc_next;
      if (state == S_FETCH) begin
        SRAM_A   <= pc;
        wait_cnt <= '0;
      end
      if (state == S_WAIT) begin
        wait_cnt <= wait_cnt + 8'd1;
        if (wait_done) ir <= SRAM_D;
      end
      if (state == S_DECODE) begin
        if (!is_note && is_bpm) bpm <= ir[11:0];
        if (!is_note && is_rep1) begin
          hi           <= ir[11:0];
          rep1_pending <= 1'b1;
        end else begin
          rep1_pending <= 1'b0;
        end
        if (is_note) begin
          NOTE_VALID <= 1'b1;
          NOTE_INS   <= ir;
          NOTE_BPM   <= bpm;
        end
        if (!is_note && is_end) DONE <= 1'b1;
        if (fault) ERR <= 1'b1;
      end
      if (accept) NOTE_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: directed score programs plus random programs,
// compared against an instruction-level interpreter of the score format.
module tb_note_sequencer;

  localparam int DEPTH     = 7;
  localparam int MEM_WORDS = 256;
  localparam int BUDGET    = 6000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [17:0] sram_a;
  logic [15:0] sram_d;
  logic        note_valid;
  logic        note_ready = 1'b0;
  logic [15:0] note_ins;
  logic [11:0] note_bpm;
  logic        done;
  logic        err;

  logic [15:0] prog [MEM_WORDS];
  int          checks = 0;
  int          failures = 0;
  int          wr_ptr = 0;
  int          first_valid_cyc = -1;

  logic [15:0] exp_ins [$];
  logic [11:0] exp_bpm [$];
  logic        exp_done;
  logic        exp_err;
  logic [17:0] exp_addr;

  note_sequencer #(.READ_WAIT(2), .DEPTH(DEPTH), .DEFAULT_BPM(12'd96)) dut (
    .CLK       (clk),
    .RESET     (reset),
    .SRAM_A    (sram_a),
    .SRAM_D    (sram_d),
    .NOTE_VALID(note_valid),
    .NOTE_READY(note_ready),
    .NOTE_INS  (note_ins),
    .NOTE_BPM  (note_bpm),
    .DONE      (done),
    .ERR       (err)
  );

  // 50 MHz clock.
  always #10 clk = ~clk;

  assign sram_d = (sram_a < 18'(MEM_WORDS)) ? prog[sram_a[7:0]] : 16'h0000;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearProgram();
    for (int i = 0; i < MEM_WORDS; i++) prog[i] = 16'h0000;
    wr_ptr = 0;
  endtask

  task automatic emit(input logic [15:0] w);
    prog[wr_ptr] = w;
    wr_ptr++;
  endtask

  task automatic emitNote();
    emit({1'b1, 15'($urandom)});
  endtask

  task automatic emitRepeat(input int t, input int n);
    logic [17:0] ta;
    ta = 18'(t);
    emit({4'h2, ta[17:6]});
    emit({4'h3, ta[5:0], 6'(n)});
  endtask

  task automatic buildRandomProgram();
    int items, kind, t_out, t_in, tail;
    clearProgram();
    items = $urandom_range(2, 6);
    for (int i = 0; i < items; i++) begin
      kind = $urandom_range(0, 9);
      if (kind < 4) begin
        emitNote();
      end else if (kind < 6) begin
        emit({4'h1, 12'($urandom_range(1, 4095))});
      end else begin
        t_out = wr_ptr;
        for (int j = 0; j < $urandom_range(1, 2); j++) emitNote();
        if ($urandom_range(0, 2) == 0) begin
          t_in = wr_ptr;
          emitNote();
          emitRepeat(t_in, $urandom_range(0, 3));
        end
        if ($urandom_range(0, 1) == 1) emitNote();
        emitRepeat(t_out, $urandom_range(0, 3));
      end
    end
    tail = $urandom_range(0, 5);
    if (tail == 0) emit({2'b01, 14'($urandom)});
    else if (tail == 1) begin
      emitNote();
      emit({4'h3, 12'($urandom)});
    end
    emit(16'h0000);
  endtask

  // Interprets the score word by word and records what the player must see.
  task automatic runModel();
    int          pc = 0;
    logic [11:0] bpm = 12'd96;
    logic [11:0] hi = 12'd0;
    bit          pending = 0;
    int          stk_addr [$];
    int          stk_cnt [$];
    logic [15:0] w;
    int          tgt, n, last;
    exp_ins.delete();
    exp_bpm.delete();
    exp_done = 0;
    exp_err  = 0;
    exp_addr = '0;
    for (int step = 0; step < 20000; step++) begin
      w = (pc < MEM_WORDS) ? prog[pc] : 16'h0000;
      if (w[15]) begin
        exp_ins.push_back(w);
        exp_bpm.push_back(bpm);
        pending = 0;
        pc = (pc + 1) % 262144;
      end else if (w[15:12] == 4'h0) begin
        exp_done = 1;
        exp_addr = 18'(pc);
        break;
      end else if (w[15:12] == 4'h1) begin
        bpm = w[11:0];
        pending = 0;
        pc = (pc + 1) % 262144;
      end else if (w[15:12] == 4'h2) begin
        hi = w[11:0];
        pending = 1;
        pc = (pc + 1) % 262144;
      end else if (w[15:12] == 4'h3) begin
        if (!pending) begin
          exp_err = 1;
          exp_addr = 18'(pc);
          break;
        end
        pending = 0;
        tgt = int'(hi) * 64 + int'(w[11:6]);
        n = int'(w[5:0]);
        last = stk_addr.size() - 1;
        if (last >= 0 && stk_addr[last] == pc) begin
          if (stk_cnt[last] == 0) begin
            void'(stk_addr.pop_back());
            void'(stk_cnt.pop_back());
            pc = (pc + 1) % 262144;
          end else begin
            stk_cnt[last] = stk_cnt[last] - 1;
            pc = tgt;
          end
        end else if (n == 0) begin
          pc = (pc + 1) % 262144;
        end else if (stk_addr.size() == DEPTH) begin
          exp_err = 1;
          exp_addr = 18'(pc);
          break;
        end else begin
          stk_addr.push_back(pc);
          stk_cnt.push_back(n - 1);
          pc = tgt;
        end
      end else begin
        exp_err = 1;
        exp_addr = 18'(pc);
        break;
      end
    end
  endtask

  // mode 0: random ready, 1: ready high, 2: first note stalled 10 cycles,
  // 3: reset pulsed while the first note is on offer, then ready high.
  task automatic applyStimulus(input int mode);
    int          got = 0, stall = 0, cyc = 0, rel = 0;
    bit          held = 0, did_reset = 0;
    logic [15:0] h_ins = '0;
    logic [11:0] h_bpm = '0;
    runModel();
    note_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_sram_a", sram_a, 0);
    checkOutput("rst_valid", note_valid, 0);
    checkOutput("rst_ins", note_ins, 0);
    checkOutput("rst_bpm", note_bpm, 96);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    reset = 1'b0;
    first_valid_cyc = -1;
    @(posedge clk);
    #1;
    cyc = 1;
    rel = 1;
    while (cyc < BUDGET && !done && !err) begin
      case (mode)
        0:       note_ready = ($urandom_range(0, 9) < 6);
        1:       note_ready = 1'b1;
        2:       note_ready = !(got == 0 && stall < 10);
        default: note_ready = did_reset;
      endcase
      @(negedge clk);
      if (note_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = rel;
        if (held) begin
          checkOutput("hold_ins", note_ins, h_ins);
          checkOutput("hold_bpm", note_bpm, h_bpm);
        end
        if (mode == 3 && !did_reset) begin
          #2 reset = 1'b1;
          #1 checkOutput("async_valid_drop", note_valid, 0);
          @(negedge clk);
          reset = 1'b0;
          did_reset = 1;
          held = 0;
          got = 0;
          rel = 0;
        end else if (note_ready) begin
          if (got < exp_ins.size()) begin
            checkOutput("note_ins", note_ins, exp_ins[got]);
            checkOutput("note_bpm", note_bpm, exp_bpm[got]);
          end else begin
            checkOutput("extra_note", got, exp_ins.size());
          end
          got++;
          held = 0;
        end else begin
          held = 1;
          h_ins = note_ins;
          h_bpm = note_bpm;
          stall++;
        end
      end else if (held) begin
        checkOutput("valid_held", note_valid, 1);
        held = 0;
      end
      @(posedge clk);
      #1;
      cyc++;
      rel++;
    end
    checkOutput("no_timeout", (cyc < BUDGET), 1);
    checkOutput("note_count", got, exp_ins.size());
    checkOutput("done", done, exp_done);
    checkOutput("err", err, exp_err);
    checkOutput("final_addr", sram_a, exp_addr);
    if (mode == 3) checkOutput("reset_seen", did_reset, 1);
    repeat (5) @(negedge clk);
    checkOutput("halt_valid", note_valid, 0);
    checkOutput("halt_addr", sram_a, exp_addr);
    checkOutput("halt_done", done, exp_done);
    checkOutput("halt_err", err, exp_err);
  endtask

  initial begin
    // Single note then end, player always ready.
    clearProgram();
    emit(16'h9234);
    emit(16'h0000);
    applyStimulus(1);
    checkOutput("first_valid_cycle", first_valid_cyc, 4);

    // BPM changes around a stalled note.
    clearProgram();
    emit(16'h1078);
    emit(16'hA111);
    emit(16'h103C);
    emit(16'hB222);
    emit(16'h0000);
    applyStimulus(2);
    checkOutput("bpm_model_a", exp_bpm[0], 12'd120);

    // Two-note body played three times.
    clearProgram();
    emit(16'h8001);
    emit(16'h8002);
    emitRepeat(0, 2);
    emit(16'h8004);
    emit(16'h0000);
    applyStimulus(0);

    // Nested repeats.
    clearProgram();
    emit(16'h8010);
    emit(16'h8011);
    emitRepeat(1, 1);
    emitRepeat(0, 1);
    emit(16'h0000);
    applyStimulus(1);

    // One nesting level too many.
    clearProgram();
    for (int k = 0; k <= DEPTH; k++) emitRepeat(2 * k + 2, 1);
    emit(16'h8123);
    emit(16'h0000);
    applyStimulus(1);

    // REP2 without its REP1.
    clearProgram();
    emit(16'h3041);
    emit(16'h0000);
    applyStimulus(1);

    // Reset while a note is on offer, then full replay.
    clearProgram();
    emit(16'h8001);
    emit(16'h8002);
    emitRepeat(0, 2);
    emit(16'h8004);
    emit(16'h0000);
    applyStimulus(3);

    // Random programs.
    for (int r = 0; r < 20; r++) begin
      buildRandomProgram();
      applyStimulus((r % 4 == 3) ? 1 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
